// File: rtl/ps2_keystroke_encoder.sv
// ASCII to PS/2 Set-2 make/break scan-code encoder with valid/ready byte streams.
// Optional macro CAPS_MODE_EN: letters are cased with Caps Lock toggles instead of a shift wrap.
module ps2_keystroke_encoder #(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       err_unsup,
  output logic       caps_on
);

  // Handshakes: a byte moves on a clock edge where valid && ready are both high;
  // once code_valid is raised, it and code_out hold until that edge occurs.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SHIFT_MK  = 4'd1;
  localparam logic [3:0] S_KEY_MK    = 4'd2;
  localparam logic [3:0] S_KEY_F0    = 4'd3;
  localparam logic [3:0] S_KEY_BRK   = 4'd4;
  localparam logic [3:0] S_SHIFT_F0  = 4'd5;
  localparam logic [3:0] S_SHIFT_BRK = 4'd6;
  localparam logic [3:0] S_GAP       = 4'd7;
`ifdef CAPS_MODE_EN
  localparam logic [3:0] S_CAPS_MK   = 4'd8;
  localparam logic [3:0] S_CAPS_F0   = 4'd9;
  localparam logic [3:0] S_CAPS_BRK  = 4'd10;
`endif

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [3:0]       state;
  logic [3:0]       resume_state;
  logic [3:0]       succ;
  logic [7:0]       key;
  logic [7:0]       lut_key;
  logic             shift_wrap;
  logic             in_upper;
  logic [GAP_W-1:0] gap_cnt;

  // Letters fold to uppercase first; 8'h00 marks an unsupported character.
  function automatic logic [7:0] key_lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
    case (u)
      8'h41: key_lookup = 8'h1C;  8'h42: key_lookup = 8'h32;  8'h43: key_lookup = 8'h21;
      8'h44: key_lookup = 8'h23;  8'h45: key_lookup = 8'h24;  8'h46: key_lookup = 8'h2B;
      8'h47: key_lookup = 8'h34;  8'h48: key_lookup = 8'h33;  8'h49: key_lookup = 8'h43;
      8'h4A: key_lookup = 8'h3B;  8'h4B: key_lookup = 8'h42;  8'h4C: key_lookup = 8'h4B;
      8'h4D: key_lookup = 8'h3A;  8'h4E: key_lookup = 8'h31;  8'h4F: key_lookup = 8'h44;
      8'h50: key_lookup = 8'h4D;  8'h51: key_lookup = 8'h15;  8'h52: key_lookup = 8'h2D;
      8'h53: key_lookup = 8'h1B;  8'h54: key_lookup = 8'h2C;  8'h55: key_lookup = 8'h3C;
      8'h56: key_lookup = 8'h2A;  8'h57: key_lookup = 8'h1D;  8'h58: key_lookup = 8'h22;
      8'h59: key_lookup = 8'h35;  8'h5A: key_lookup = 8'h1A;
      8'h30: key_lookup = 8'h45;  8'h31: key_lookup = 8'h16;  8'h32: key_lookup = 8'h1E;
      8'h33: key_lookup = 8'h26;  8'h34: key_lookup = 8'h25;  8'h35: key_lookup = 8'h2E;
      8'h36: key_lookup = 8'h36;  8'h37: key_lookup = 8'h3D;  8'h38: key_lookup = 8'h3E;
      8'h39: key_lookup = 8'h46;
      8'h20: key_lookup = 8'h29;
      8'h0D: key_lookup = 8'h5A;
      default: key_lookup = 8'h00;
    endcase
  endfunction

  assign lut_key     = key_lookup(ascii_in);
  assign in_upper    = (ascii_in >= 8'h41) && (ascii_in <= 8'h5A);
  assign ascii_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

`ifdef CAPS_MODE_EN
  logic caps_q;
  logic in_letter;
  assign in_letter = in_upper || ((ascii_in >= 8'h61) && (ascii_in <= 8'h7A));
  assign caps_on   = caps_q;
`else
  assign caps_on = 1'b0;
`endif

  always_comb begin
    code_out   = 8'h00;
    code_valid = 1'b1;
    succ       = S_IDLE;
    case (state)
      S_SHIFT_MK:  begin code_out = 8'h12; succ = S_KEY_MK;   end
      S_KEY_MK:    begin code_out = key;   succ = S_KEY_F0;   end
      S_KEY_F0:    begin code_out = 8'hF0; succ = S_KEY_BRK;  end
      S_KEY_BRK:   begin code_out = key;   succ = shift_wrap ? S_SHIFT_F0 : S_IDLE; end
      S_SHIFT_F0:  begin code_out = 8'hF0; succ = S_SHIFT_BRK; end
      S_SHIFT_BRK: begin code_out = 8'h12; succ = S_IDLE;     end
`ifdef CAPS_MODE_EN
      S_CAPS_MK:   begin code_out = 8'h58; succ = S_CAPS_F0;  end
      S_CAPS_F0:   begin code_out = 8'hF0; succ = S_CAPS_BRK; end
      S_CAPS_BRK:  begin code_out = 8'h58; succ = S_KEY_MK;   end
`endif
      default:     code_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      resume_state <= S_IDLE;
      key          <= 8'h00;
      shift_wrap   <= 1'b0;
      gap_cnt      <= '0;
      err_unsup    <= 1'b0;
`ifdef CAPS_MODE_EN
      caps_q       <= 1'b0;
`endif
    end else begin
      err_unsup <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ascii_valid) begin
            key <= lut_key;
            if (lut_key == 8'h00) begin
              err_unsup <= 1'b1;
            end else begin
`ifdef CAPS_MODE_EN
              shift_wrap <= 1'b0;
              state      <= (in_letter && (in_upper != caps_q)) ? S_CAPS_MK : S_KEY_MK;
`else
              shift_wrap <= in_upper;
              state      <= in_upper ? S_SHIFT_MK : S_KEY_MK;
`endif
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= resume_state;
          else gap_cnt <= gap_cnt + GAP_ONE;
        end
        default: begin
          if (!code_valid) begin
            state <= S_IDLE;
          end else if (code_ready) begin
`ifdef CAPS_MODE_EN
            if (state == S_CAPS_BRK) caps_q <= ~caps_q;
`endif
            // The trailing gap also follows the last byte of a sequence.
            if (GAP_CYCLES > 0) begin
              state        <= S_GAP;
              resume_state <= succ;
              gap_cnt      <= '0;
            end else begin
              state <= succ;
            end
          end
        end
      endcase
    end
  end

endmodule
